// File: rtl/booth_multiplier_n.sv
// Sequential radix-2 Booth multiplier: IDLE/RUN/DONE FSM, one Booth step per clock, WIDTH+1 steps.
// Define BOOTH_SIGNED_MODE_EN to honour signed_mode; otherwise operands are always two's complement.
module booth_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   Output,
  output logic                 ready
);

  localparam int XW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [XW-1:0]       mcand_q, mcand_d;
  logic [XW-1:0]       acc_q, acc_d;
  logic [XW-1:0]       mq_q, mq_d;
  logic                qm1_q, qm1_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  out_q, out_d;
  logic                ready_q, ready_d;

  logic                sm_eff;
  logic [XW-1:0]       a_ext, b_ext;
  logic [XW-1:0]       acc_sum;
  logic [XW-1:0]       acc_sh, mq_sh;
  logic                qm1_sh;

`ifdef BOOTH_SIGNED_MODE_EN
  assign sm_eff = signed_mode;
`else
  assign sm_eff = signed_mode | 1'b1;
`endif

  always_comb begin
    a_ext = {sm_eff & A[WIDTH-1], A};
    b_ext = {sm_eff & B[WIDTH-1], B};

    // One Booth step: add/subtract per (q0, q-1), then arithmetic shift of {acc, q, q-1}
    case ({mq_q[0], qm1_q})
      2'b01:   acc_sum = acc_q + mcand_q;
      2'b10:   acc_sum = acc_q - mcand_q;
      default: acc_sum = acc_q;
    endcase
    {acc_sh, mq_sh, qm1_sh} = {acc_sum[XW-1], acc_sum, mq_q};

    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ready_d = ready_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          mcand_d = a_ext;
          mq_d    = b_ext;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        qm1_d = qm1_sh;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH)) begin
          out_d   = {acc_sh[WIDTH-2:0], mq_sh};
          ready_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!en) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign Output = out_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_booth_multiplier_n.sv
// Self-checking bench for booth_multiplier_n (WIDTH=8) against a plain-arithmetic product model.
module tb_booth_multiplier_n;

  localparam int W = 8;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic           signed_mode = 1'b0;
  logic [2*W-1:0] Output;
  logic           ready;

  int vectors = 0;
  int errors = 0;

  booth_multiplier_n #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .A(A),
    .B(B),
    .signed_mode(signed_mode),
    .Output(Output),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference: extend each operand to an integer and multiply; keep the low 2*W bits
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm);
    logic   use_signed;
    longint av, bv, p;
`ifdef BOOTH_SIGNED_MODE_EN
    use_signed = sm;
`else
    use_signed = sm | 1'b1;
`endif
    av = use_signed ? longint'($signed(a)) : longint'(a);
    bv = use_signed ? longint'($signed(b)) : longint'(b);
    p  = av * bv;
    return p[2*W-1:0];
  endfunction

  // Issue one request from IDLE and wait (bounded) for ready; reports latency and result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input bit scramble, output int lat, output logic [2*W-1:0] early,
                        output logic [2*W-1:0] res);
    A = a;
    B = b;
    signed_mode = sm;
    en = 1'b1;
    @(posedge clk); #1;
    early = Output;
    if (scramble) begin
      A = '0;
      B = '0;
      signed_mode = ~sm;
      en = 1'b0;
    end
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = Output;
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    logic [2*W-1:0] early, res, exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (Output !== '0 || ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: Output=%h ready=%b, required Output=0000 ready=0", Output, ready);
    end
    rst = 1'b0;
    run_op(8'd5, 8'd9, 1'b0, 1'b0, lat, early, res);
    exp = model(8'd5, 8'd9, 1'b0);
    vectors++;
    if (lat !== LAT || res !== exp) begin
      errors++;
      $display("[TB] FAIL first_edge_capture: lat=%0d res=%h, required lat=%0d res=%h", lat, res, LAT, exp);
    end
    go_idle();
  endtask

  task automatic test_directed();
    logic [W-1:0] av [7] = '{8'd129, 8'd129, 8'h80, 8'h80, 8'd255, 8'd7, 8'd3};
    logic [W-1:0] bv [7] = '{8'd1,   8'd1,   8'h80, 8'h80, 8'd255, 8'd6, 8'hFE};
    logic         sv [7] = '{1'b0,   1'b1,   1'b1,  1'b0,  1'b0,   1'b0, 1'b1};
    int lat;
    logic [2*W-1:0] early, res, exp;
    for (int i = 0; i < 7; i++) begin
      run_op(av[i], bv[i], sv[i], 1'b0, lat, early, res);
      exp = model(av[i], bv[i], sv[i]);
      vectors++;
      if (lat !== LAT || res !== exp) begin
        errors++;
        $display("[TB] FAIL directed_%0d: lat=%0d res=%h, required lat=%0d res=%h", i, lat, res, LAT, exp);
      end
      // en stays high in DONE: result and ready must hold, no restart
      repeat (12) @(posedge clk);
      #1;
      vectors++;
      if (Output !== exp || ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL done_hold_%0d: Output=%h ready=%b, required Output=%h ready=1", i, Output, ready, exp);
      end
      go_idle();
    end
    vectors++;
    if (model(8'h80, 8'h80, 1'b1) !== 16'h4000 || model(8'd3, 8'hFE, 1'b1) !== 16'hFFFA) begin
      errors++;
      $display("[TB] FAIL model_sanity: %h %h, required 4000 fffa",
               model(8'h80, 8'h80, 1'b1), model(8'd3, 8'hFE, 1'b1));
    end
  endtask

  task automatic test_change_during_run();
    int lat;
    logic [2*W-1:0] early, res, exp;
    run_op(8'd255, 8'd255, 1'b0, 1'b1, lat, early, res);
    exp = model(8'd255, 8'd255, 1'b0);
    vectors++;
    if (lat !== LAT || res !== exp) begin
      errors++;
      $display("[TB] FAIL inputs_changed_in_run: lat=%0d res=%h, required lat=%0d res=%h", lat, res, LAT, exp);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || Output !== exp) begin
      errors++;
      $display("[TB] FAIL done_to_idle: ready=%b Output=%h, required ready=0 Output=%h", ready, Output, exp);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [2*W-1:0] early, res, exp;
    A = 8'd255;
    B = 8'd255;
    signed_mode = 1'b0;
    en = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    en = 1'b0;
    vectors++;
    if (ready !== 1'b0 || Output !== '0) begin
      errors++;
      $display("[TB] FAIL reset_abort: ready=%b Output=%h, required ready=0 Output=0000", ready, Output);
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b0 || Output !== '0) begin
      errors++;
      $display("[TB] FAIL no_partial_result: ready=%b Output=%h, required ready=0 Output=0000", ready, Output);
    end
    run_op(8'd3, 8'hFE, 1'b1, 1'b0, lat, early, res);
    exp = model(8'd3, 8'hFE, 1'b1);
    vectors++;
    if (lat !== LAT || res !== exp) begin
      errors++;
      $display("[TB] FAIL after_abort: lat=%0d res=%h, required lat=%0d res=%h", lat, res, LAT, exp);
    end
    go_idle();
  endtask

  task automatic test_idle_hold();
    int lat;
    logic [2*W-1:0] early, res, prev, exp;
    run_op(8'd200, 8'd13, 1'b1, 1'b0, lat, early, prev);
    go_idle();
    vectors++;
    if (ready !== 1'b0 || Output !== prev) begin
      errors++;
      $display("[TB] FAIL idle_hold: ready=%b Output=%h, required ready=0 Output=%h", ready, Output, prev);
    end
    run_op(8'd7, 8'd6, 1'b0, 1'b0, lat, early, res);
    exp = model(8'd7, 8'd6, 1'b0);
    vectors++;
    if (early !== prev) begin
      errors++;
      $display("[TB] FAIL held_during_run: Output=%h, required %h", early, prev);
    end
    vectors++;
    if (lat !== LAT || res !== exp) begin
      errors++;
      $display("[TB] FAIL next_request: lat=%0d res=%h, required lat=%0d res=%h", lat, res, LAT, exp);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2*W-1:0] early, res, exp;
    logic [W-1:0] a, b;
    logic sm;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      sm = 1'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'h7F; end
      if (i == 1) begin a = 8'h00; b = 8'hFF; end
      run_op(a, b, sm, 1'($urandom), lat, early, res);
      exp = model(a, b, sm);
      vectors++;
      if (lat !== LAT || res !== exp) begin
        errors++;
        $display("[TB] FAIL random_%0d a=%h b=%h sm=%b: lat=%0d res=%h, required lat=%0d res=%h",
                 i, a, b, sm, lat, res, LAT, exp);
      end
      go_idle();
    end
  endtask

  initial begin
    $display("[TB] booth_multiplier_n WIDTH=%0d", W);
    test_reset();
    test_directed();
    test_change_during_run();
    test_reset_abort();
    test_idle_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
